// File: rtl/decode_top.sv
// Registered instruction decoder: priority mask/match tables for short (12-bit) and long
// (24-bit) forms, expanding each instruction into up to two uop tags.

package uop_pkg;

    typedef enum logic [4:0] {
        UOP_INT_ALU            = 5'd0,
        UOP_PREFIX_SELECT      = 5'd1,
        UOP_PREFIX_CANCEL      = 5'd2,
        UOP_INT_SAT_ADD        = 5'd3,
        UOP_INT_SAT_SUB        = 5'd4,
        UOP_LD_U8              = 5'd5,
        UOP_ST_U8              = 5'd6,
        UOP_CSR_ALIAS_RD       = 5'd7,
        UOP_PACK_ADD_SAT       = 5'd8,
        UOP_PACK_SUB_SAT       = 5'd9,
        UOP_PACK_AVG           = 5'd10,
        UOP_PACK_MINMAX        = 5'd11,
        UOP_MEM_PREFETCH       = 5'd12,
        UOP_CAP_FENCE_PREFIX   = 5'd13,
        UOP_CAP_CLONE_RESTRICT = 5'd14,
        UOP_CAP_LOAN_END       = 5'd15,
        UOP_CAP_LOAN_BEGIN     = 5'd16,
        UOP_INT_BRANCH         = 5'd17,
        UOP_CAP_JUMP           = 5'd18,
        UOP_LINK               = 5'd19,
        UOP_CAP_RET            = 5'd20,
        UOP_LR128              = 5'd21,
        UOP_SC128              = 5'd22,
        UOP_CAS128             = 5'd23,
        UOP_ST128_MASK         = 5'd24
    } uop_tag_t;

endpackage

module decode_top
    import uop_pkg::*;
#(
    parameter int unsigned MAX_UOPS = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [23:0] instr_i,
    input  logic        instr_is_long_i,
    output uop_tag_t    uop_tag0_o,
    output uop_tag_t    uop_tag1_o,
    output logic [1:0]  uop_count_o,
    output logic        match_valid_o
);

    logic [11:0] short_instr;
    logic        hit;
    logic        dual;
    uop_tag_t    hit_tag;

    logic        match_d, match_q;
    logic [1:0]  count_d, count_q;
    uop_tag_t    tag0_d, tag0_q;
    uop_tag_t    tag1_d, tag1_q;

    assign short_instr = instr_i[11:0];

    // Priority chains: earlier entries shadow later overlapping ones.
    always_comb begin
        hit     = 1'b1;
        dual    = 1'b0;
        hit_tag = UOP_INT_ALU;
        if (!instr_is_long_i) begin
            if ((short_instr & 12'hFFF) == 12'hE00) begin
                hit_tag = UOP_PREFIX_SELECT;
            end else if ((short_instr & 12'hFFF) == 12'hE07) begin
                hit_tag = UOP_PREFIX_CANCEL;
            end else if ((short_instr & 12'hF0F) == 12'hA00) begin
                hit_tag = UOP_INT_SAT_ADD;
            end else if ((short_instr & 12'hF0F) == 12'hA01) begin
                hit_tag = UOP_INT_SAT_SUB;
            end else if ((short_instr & 12'hF0F) == 12'h800) begin
                hit_tag = UOP_LD_U8;
            end else if ((short_instr & 12'hF0F) == 12'h801) begin
                hit_tag = UOP_ST_U8;
            end else if ((short_instr & 12'hFFF) == 12'hC02) begin
                hit_tag = UOP_CSR_ALIAS_RD;
            end else begin
                hit = 1'b0;
            end
        end else begin
            if ((instr_i & 24'hF000F0) == 24'h500000) begin
                hit_tag = UOP_PACK_ADD_SAT;
            end else if ((instr_i & 24'hF000F0) == 24'h500010) begin
                hit_tag = UOP_PACK_SUB_SAT;
            end else if ((instr_i & 24'hF000F0) == 24'h500020) begin
                hit_tag = UOP_PACK_AVG;
            end else if ((instr_i & 24'hF000F0) == 24'h500030) begin
                hit_tag = UOP_PACK_MINMAX;
            end else if ((instr_i & 24'hF00000) == 24'h600000) begin
                hit_tag = UOP_MEM_PREFETCH;
            end else if ((instr_i & 24'hF00000) == 24'h700000) begin
                hit_tag = UOP_CAP_FENCE_PREFIX;
            end else if ((instr_i & 24'hF00000) == 24'h800000) begin
                hit_tag = UOP_CAP_CLONE_RESTRICT;
            end else if ((instr_i & 24'hF00FFF) == 24'h900FF1) begin
                hit_tag = UOP_CAP_LOAN_END;
            end else if ((instr_i & 24'hF00000) == 24'h900000) begin
                hit_tag = UOP_CAP_LOAN_BEGIN;
            end else if ((instr_i & 24'hF00000) == 24'h300000) begin
                hit_tag = UOP_INT_BRANCH;
            end else if ((instr_i & 24'hF000F0) == 24'h400040) begin
                hit_tag = UOP_CAP_JUMP;
                dual    = 1'b1;
            end else if ((instr_i & 24'hF0000F) == 24'h200004) begin
                hit_tag = UOP_CAP_JUMP;
            end else if ((instr_i & 24'hF0000F) == 24'h200001) begin
                hit_tag = UOP_CAP_RET;
            end else if ((instr_i & 24'hF0000F) == 24'hC00000) begin
                hit_tag = UOP_LR128;
            end else if ((instr_i & 24'hF0000F) == 24'hC00001) begin
                hit_tag = UOP_SC128;
            end else if ((instr_i & 24'hF0000F) == 24'hC00002) begin
                hit_tag = UOP_CAS128;
            end else if ((instr_i & 24'hF0000F) == 24'hC00003) begin
                hit_tag = UOP_ST128_MASK;
            end else begin
                hit = 1'b0;
            end
        end
    end

    // The dual entry reports two uops even when the second slot cannot carry LINK.
    always_comb begin
        match_d = hit;
        count_d = 2'd0;
        tag0_d  = hit_tag;
        tag1_d  = UOP_INT_ALU;
        if (hit) begin
            count_d = dual ? 2'd2 : 2'd1;
            if (dual && (MAX_UOPS >= 2)) begin
                tag1_d = UOP_LINK;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            match_q <= 1'b0;
            count_q <= 2'd0;
            tag0_q  <= UOP_INT_ALU;
            tag1_q  <= UOP_INT_ALU;
        end else begin
            match_q <= match_d;
            count_q <= count_d;
            tag0_q  <= tag0_d;
            tag1_q  <= tag1_d;
        end
    end

    assign match_valid_o = match_q;
    assign uop_count_o   = count_q;
    assign uop_tag0_o    = tag0_q;
    assign uop_tag1_o    = tag1_q;

endmodule

// File: tb/tb_decode_top.sv
// Self-checking bench for decode_top: fixed vectors, reset corner cases and random stimulus
// against a table-scanning reference model; runs MAX_UOPS=2 and MAX_UOPS=1 instances in parallel.

module tb_decode_top;
    import uop_pkg::*;

    logic        clk;
    logic        rst_ni;
    logic [23:0] instr;
    logic        is_long;

    uop_tag_t    t0_2, t1_2, t0_1, t1_1;
    logic [1:0]  cnt_2, cnt_1;
    logic        mv_2, mv_1;

    int checks;
    int errors;

    decode_top #(.MAX_UOPS(2)) dut2 (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_i        (instr),
        .instr_is_long_i(is_long),
        .uop_tag0_o     (t0_2),
        .uop_tag1_o     (t1_2),
        .uop_count_o    (cnt_2),
        .match_valid_o  (mv_2)
    );

    decode_top #(.MAX_UOPS(1)) dut1 (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_i        (instr),
        .instr_is_long_i(is_long),
        .uop_tag0_o     (t0_1),
        .uop_tag1_o     (t1_1),
        .uop_count_o    (cnt_1),
        .match_valid_o  (mv_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference tables, listed in priority order.
    logic [11:0] smask [7];
    logic [11:0] smatch[7];
    uop_tag_t    stag  [7];
    logic [23:0] lmask [17];
    logic [23:0] lmatch[17];
    uop_tag_t    ltag  [17];
    logic        ldual [17];

    typedef struct {
        logic        lng;
        logic [23:0] ins;
        logic        m;
        logic [1:0]  c;
        uop_tag_t    t0;
        uop_tag_t    t1_two;
        uop_tag_t    t1_one;
    } vec_t;

    vec_t vecs[$];

    task automatic set_s(input int i, input logic [11:0] mk, input logic [11:0] mt,
                         input uop_tag_t t);
        smask[i] = mk; smatch[i] = mt; stag[i] = t;
    endtask

    task automatic set_l(input int i, input logic [23:0] mk, input logic [23:0] mt,
                         input uop_tag_t t, input logic d);
        lmask[i] = mk; lmatch[i] = mt; ltag[i] = t; ldual[i] = d;
    endtask

    task automatic model(input logic lng, input logic [23:0] ins, output logic m,
                         output logic [1:0] c, output uop_tag_t t0, output uop_tag_t t1_two,
                         output uop_tag_t t1_one);
        logic [11:0] s;
        m = 1'b0; c = 2'd0; t0 = UOP_INT_ALU; t1_two = UOP_INT_ALU; t1_one = UOP_INT_ALU;
        s = ins[11:0];
        if (!lng) begin
            for (int i = 0; i < 7; i++) begin
                if (!m && ((s & smask[i]) == smatch[i])) begin
                    m = 1'b1; c = 2'd1; t0 = stag[i];
                end
            end
        end else begin
            for (int i = 0; i < 17; i++) begin
                if (!m && ((ins & lmask[i]) == lmatch[i])) begin
                    m = 1'b1; t0 = ltag[i];
                    c = ldual[i] ? 2'd2 : 2'd1;
                    if (ldual[i]) t1_two = UOP_LINK;
                end
            end
        end
    endtask

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input logic m, input logic [1:0] c,
                             input uop_tag_t t0, input uop_tag_t t1_two, input uop_tag_t t1_one);
        cmp({name, " match2"}, int'(mv_2), int'(m));
        cmp({name, " count2"}, int'(cnt_2), int'(c));
        cmp({name, " tag0_2"}, int'(t0_2), int'(t0));
        cmp({name, " tag1_2"}, int'(t1_2), int'(t1_two));
        cmp({name, " match1"}, int'(mv_1), int'(m));
        cmp({name, " count1"}, int'(cnt_1), int'(c));
        cmp({name, " tag0_1"}, int'(t0_1), int'(t0));
        cmp({name, " tag1_1"}, int'(t1_1), int'(t1_one));
    endtask

    task automatic apply(input logic lng, input logic [23:0] ins);
        @(negedge clk);
        is_long = lng;
        instr   = ins;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic lng, input logic [23:0] ins, input logic m,
                       input logic [1:0] c, input uop_tag_t t0, input uop_tag_t t1_two,
                       input uop_tag_t t1_one);
        vec_t v;
        v.lng = lng; v.ins = ins; v.m = m; v.c = c; v.t0 = t0;
        v.t1_two = t1_two; v.t1_one = t1_one;
        vecs.push_back(v);
    endtask

    initial begin
        logic        m;
        logic [1:0]  c;
        uop_tag_t    e0, e1a, e1b;
        logic [23:0] r;
        checks = 0;
        errors = 0;

        set_s(0, 12'hFFF, 12'hE00, UOP_PREFIX_SELECT);
        set_s(1, 12'hFFF, 12'hE07, UOP_PREFIX_CANCEL);
        set_s(2, 12'hF0F, 12'hA00, UOP_INT_SAT_ADD);
        set_s(3, 12'hF0F, 12'hA01, UOP_INT_SAT_SUB);
        set_s(4, 12'hF0F, 12'h800, UOP_LD_U8);
        set_s(5, 12'hF0F, 12'h801, UOP_ST_U8);
        set_s(6, 12'hFFF, 12'hC02, UOP_CSR_ALIAS_RD);
        set_l(0,  24'hF000F0, 24'h500000, UOP_PACK_ADD_SAT, 1'b0);
        set_l(1,  24'hF000F0, 24'h500010, UOP_PACK_SUB_SAT, 1'b0);
        set_l(2,  24'hF000F0, 24'h500020, UOP_PACK_AVG, 1'b0);
        set_l(3,  24'hF000F0, 24'h500030, UOP_PACK_MINMAX, 1'b0);
        set_l(4,  24'hF00000, 24'h600000, UOP_MEM_PREFETCH, 1'b0);
        set_l(5,  24'hF00000, 24'h700000, UOP_CAP_FENCE_PREFIX, 1'b0);
        set_l(6,  24'hF00000, 24'h800000, UOP_CAP_CLONE_RESTRICT, 1'b0);
        set_l(7,  24'hF00FFF, 24'h900FF1, UOP_CAP_LOAN_END, 1'b0);
        set_l(8,  24'hF00000, 24'h900000, UOP_CAP_LOAN_BEGIN, 1'b0);
        set_l(9,  24'hF00000, 24'h300000, UOP_INT_BRANCH, 1'b0);
        set_l(10, 24'hF000F0, 24'h400040, UOP_CAP_JUMP, 1'b1);
        set_l(11, 24'hF0000F, 24'h200004, UOP_CAP_JUMP, 1'b0);
        set_l(12, 24'hF0000F, 24'h200001, UOP_CAP_RET, 1'b0);
        set_l(13, 24'hF0000F, 24'hC00000, UOP_LR128, 1'b0);
        set_l(14, 24'hF0000F, 24'hC00001, UOP_SC128, 1'b0);
        set_l(15, 24'hF0000F, 24'hC00002, UOP_CAS128, 1'b0);
        set_l(16, 24'hF0000F, 24'hC00003, UOP_ST128_MASK, 1'b0);

        // Hand-derived expectations; upper bits on short entries must be ignored.
        add(0, 24'h000E00, 1, 2'd1, UOP_PREFIX_SELECT, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'hFFFE07, 1, 2'd1, UOP_PREFIX_CANCEL, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000A00, 1, 2'd1, UOP_INT_SAT_ADD, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000A40, 1, 2'd1, UOP_INT_SAT_ADD, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h500A11, 1, 2'd1, UOP_INT_SAT_SUB, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000800, 1, 2'd1, UOP_LD_U8, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000820, 1, 2'd1, UOP_LD_U8, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000801, 1, 2'd1, UOP_ST_U8, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000C02, 1, 2'd1, UOP_CSR_ALIAS_RD, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000123, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h000040, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h012345, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h000E00, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h800123, 1, 2'd1, UOP_CAP_CLONE_RESTRICT, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h900FF1, 1, 2'd1, UOP_CAP_LOAN_END, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h900ABC, 1, 2'd1, UOP_CAP_LOAN_BEGIN, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h500010, 1, 2'd1, UOP_PACK_SUB_SAT, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h200004, 1, 2'd1, UOP_CAP_JUMP, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h200001, 1, 2'd1, UOP_CAP_RET, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'hC00003, 1, 2'd1, UOP_ST128_MASK, UOP_INT_ALU, UOP_INT_ALU);
        add(1, 24'h400040, 1, 2'd2, UOP_CAP_JUMP, UOP_LINK, UOP_INT_ALU);
        add(1, 24'h000C02, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        add(0, 24'h400040, 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);

        // Reset held with a hitting instruction present: outputs stay cleared.
        rst_ni  = 1'b0;
        is_long = 1'b0;
        instr   = 24'h000E00;
        repeat (3) @(posedge clk);
        #1;
        check_all("reset", 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        @(negedge clk);
        rst_ni = 1'b1;
        #1;
        check_all("release_no_edge", 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);

        foreach (vecs[i]) begin
            apply(vecs[i].lng, vecs[i].ins);
            check_all($sformatf("vec%0d_%06h", i, vecs[i].ins), vecs[i].m, vecs[i].c,
                      vecs[i].t0, vecs[i].t1_two, vecs[i].t1_one);
        end

        // Mid-stream async reset while showing a dual hit.
        apply(1'b1, 24'h400040);
        check_all("pre_reset_hit", 1, 2'd2, UOP_CAP_JUMP, UOP_LINK, UOP_INT_ALU);
        rst_ni = 1'b0;
        #2;
        check_all("async_clear", 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        @(negedge clk);
        is_long = 1'b1;
        instr   = 24'h500010;
        rst_ni  = 1'b1;
        #1;
        check_all("post_release", 0, 2'd0, UOP_INT_ALU, UOP_INT_ALU, UOP_INT_ALU);
        @(posedge clk);
        #1;
        check_all("first_after_reset", 1, 2'd1, UOP_PACK_SUB_SAT, UOP_INT_ALU, UOP_INT_ALU);

        // Random alternating long/short stream, biased toward table hits.
        for (int i = 0; i < 400; i++) begin
            r = 24'($urandom);
            if ($urandom_range(0, 3) != 0) begin
                if (i % 2 == 0) r[23:20] = 4'($urandom_range(2, 12));
                else            r[11:8]  = 4'($urandom_range(8, 14));
                if ($urandom_range(0, 1) == 1) r[7:4] = 4'($urandom_range(0, 4));
                if ($urandom_range(0, 1) == 1) r[3:0] = 4'($urandom_range(0, 7));
            end
            apply(i % 2 == 0, r);
            model(i % 2 == 0, r, m, c, e0, e1a, e1b);
            check_all($sformatf("rand%0d_%0d_%06h", i, i % 2 == 0, r), m, c, e0, e1a, e1b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
